// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the program/data memory arbiter.
//   ArbAw / ArbDw : default address and data widths of the memory bus
//   CntW          : width of the per-grant host transaction counter
//   arb_state_e   : arbiter ownership state
//   host_owns()   : true in the states where the host drives the memory
package mem_arbiter_pkg;

    localparam int unsigned ArbAw = 5;
    localparam int unsigned ArbDw = 8;
    localparam int unsigned CntW  = 8;

    typedef enum logic [2:0] {
        StCpu,
        StDrain,
        StHost,
        StHwr,
        StHrd1,
        StHrd2,
        StRelease
    } arb_state_e;

    function automatic logic host_owns(arb_state_e s);
        return (s == StHost) || (s == StHwr) || (s == StHrd1) || (s == StHrd2);
    endfunction

endpackage

// File: rtl/mem_arbiter_txn_counter.sv
// Host transaction counter and fairness flag for the memory arbiter.
//   clk, rst_n    : clock, asynchronous active-low reset
//   inc           : one host transaction accepted this cycle
//   clr           : clear the count (grant is being released)
//   set_fair      : host grant just ended, CPU must run one instruction
//   cpu_boundary  : CPU instruction-boundary indication
//   at_limit      : count has reached HOST_MAX
//   fair          : host re-grant is blocked
module mem_arbiter_txn_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned HOST_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    input  logic set_fair,
    input  logic cpu_boundary,
    output logic at_limit,
    output logic fair
);

    localparam logic [CntW-1:0] Limit = CntW'(HOST_MAX);

    logic [CntW-1:0] count_q, count_d;
    logic            fair_q, fair_d;
    logic            seen_low_q, seen_low_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 8'd1;
        end
    end

    // Fairness: once set, wait for the boundary to be seen low, then high
    // again; that re-rise marks a complete CPU instruction.
    always_comb begin
        fair_d     = fair_q;
        seen_low_d = seen_low_q;
        if (set_fair) begin
            fair_d     = 1'b1;
            seen_low_d = 1'b0;
        end else if (fair_q) begin
            if (!cpu_boundary) begin
                seen_low_d = 1'b1;
            end else if (seen_low_q) begin
                fair_d     = 1'b0;
                seen_low_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            fair_q     <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            fair_q     <= fair_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign at_limit = (count_q == Limit);
    assign fair     = fair_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port program/data memory.
// The CPU owns the memory by default; the host may take it only at a CPU
// instruction boundary while the CPU is frozen by cpu_hold.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cpu_rd/wr/addr/wdata            : CPU memory request (pass-through when CPU owns)
//   cpu_rdata                       : memory read data to CPU (always mem_rdata)
//   cpu_boundary                    : CPU is at first fetch state, nothing pending
//   cpu_hold                        : freezes the CPU state register
//   host_req / host_gnt             : host ownership request / grant
//   host_valid/we/addr/wdata/ready  : host transaction handshake
//   host_rdata / host_rvalid        : host read return, one-cycle strobe
//   mem_rd/wr/addr/wdata/rdata      : memory macro port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = ArbAw,
    parameter int unsigned DW       = ArbDw,
    parameter int unsigned HOST_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    // CPU side
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          cpu_boundary,
    output logic          cpu_hold,
    // Host side
    input  logic          host_req,
    output logic          host_gnt,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    // Memory side
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;

    logic capture;
    logic cnt_inc;
    logic cnt_clr;
    logic set_fair;
    logic at_limit;
    logic fair;

    mem_arbiter_txn_counter #(
        .HOST_MAX (HOST_MAX)
    ) u_txn_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc          (cnt_inc),
        .clr          (cnt_clr),
        .set_fair     (set_fair),
        .cpu_boundary (cpu_boundary),
        .at_limit     (at_limit),
        .fair         (fair)
    );

    always_comb begin
        state_d    = state_q;
        cpu_hold   = 1'b1;
        host_gnt   = host_owns(state_q);
        host_ready = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        capture    = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        set_fair   = 1'b0;

        unique case (state_q)
            StCpu: begin
                cpu_hold  = 1'b0;
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (host_req && !fair) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // CPU is frozen but its last strobes still reach the memory.
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (!host_req) begin
                    state_d = StCpu;
                end else if (cpu_boundary) begin
                    state_d = StHost;
                end
            end
            StHost: begin
                // Refuse further work once the per-grant quota is used up.
                host_ready = !at_limit;
                if (at_limit) begin
                    state_d = StRelease;
                end else if (host_valid) begin
                    capture = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = host_we ? StHwr : StHrd1;
                end else if (!host_req) begin
                    state_d = StRelease;
                end
            end
            StHwr: begin
                mem_wr  = 1'b1;
                state_d = StHost;
            end
            StHrd1: begin
                mem_rd  = 1'b1;
                state_d = StHrd2;
            end
            StHrd2: begin
                mem_rd  = 1'b1;
                state_d = StHost;
            end
            StRelease: begin
                cnt_clr  = 1'b1;
                set_fair = 1'b1;
                state_d  = StCpu;
            end
            default: begin
                state_d = StCpu;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StCpu;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (state_q == StHrd2);
            if (capture) begin
                addr_q  <= host_addr;
                wdata_q <= host_wdata;
            end
            if (state_q == StHrd2) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = rdata_q;
    assign host_rvalid = rvalid_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the CPU's single-port program/data memory. The CPU bus (driven by the instruction-sequencing controller) owns the memory by default. A host port (program loader / debug) can take ownership only at an instruction boundary, while the CPU is frozen via `cpu_hold`. The block sits between the CPU core, the host interface and the memory macro.

## Interface
- `AW`, 5, address width
- `DW`, 8, data width
- `HOST_MAX`, 16, max host transactions per grant before forced release (1..255)
- `clk  in  1  single clock, all state on rising edge`
- `rst_  in  1  asynchronous, active-low reset`
- `cpu_rd, cpu_wr  in  1 each  CPU memory strobes`
- `cpu_addr  in  AW  CPU address`
- `cpu_wdata  in  DW  CPU write data`
- `cpu_rdata  out  DW  memory read data to CPU`
- `cpu_boundary  in  1  high while CPU is in its first fetch state with no rd/wr pending`
- `cpu_hold  out  1  freezes CPU state register while high`
- `host_req  in  1  host requests ownership (level)`
- `host_gnt  out  1  host owns memory`
- `host_valid, host_we  in  1 each  transaction request / write-not-read`
- `host_addr  in  AW`, `host_wdata  in  DW`
- `host_ready  out  1  transaction accepted when valid&ready`
- `host_rdata  out  DW`, `host_rvalid  out  1  one-cycle read-data strobe`
- `mem_rd, mem_wr  out  1 each`, `mem_addr  out  AW`, `mem_wdata  out  DW`, `mem_rdata  in  DW`

## Operation
- States: CPU, DRAIN, HOST, HWR, HRD1, HRD2, RELEASE. Reset -> CPU.
- CPU: mem_* = cpu_* combinationally; cpu_rdata = mem_rdata always. host_req -> DRAIN.
- DRAIN: cpu_hold=1, mem_* still from CPU. Leave to HOST on the first cycle cpu_boundary=1 sampled with hold already high. host_req dropped -> CPU (hold released next cycle).
- HOST: host_gnt=1, host_ready=1, mem strobes 0. valid&ready: capture addr/wdata/we into regs, counter+1; we -> HWR, else HRD1. host_req low with no valid, or counter==HOST_MAX -> RELEASE.
- HWR: mem_wr=1 with registered addr/data; -> HOST.
- HRD1: mem_rd=1 (address setup); -> HRD2. HRD2: mem_rd=1, host_rdata<=mem_rdata at edge, host_rvalid=1 next cycle; -> HOST.
- RELEASE: gnt=0, hold=1, strobes 0; counter cleared; -> CPU, with a `fair` flag set.
- `fair` blocks CPU->DRAIN until cpu_boundary has fallen and risen again (one full CPU instruction executes between host grants). Cleared on that re-rise.
- Counter 8-bit, saturates never (cleared before exceeding HOST_MAX).
- host_req dropped mid-transaction: the transaction finishes, then RELEASE.

## Timing
- Reset values: cpu_hold=0, host_gnt=0, host_ready=0, host_rvalid=0, host_rdata=0, mem_rd=mem_wr=0 (CPU strobes held low by CPU reset), counter=0, fair=0.
- CPU path: zero latency, purely combinational in CPU state.
- Grant latency: req at cycle N -> DRAIN N+1 (hold=1) -> HOST at the first edge after boundary is seen, at the earliest N+2.
- Host write: accept N, mem_wr at N+1, ready=0 at N+1, ready=1 at N+2.
- Host read: accept N, mem_rd at N+1 and N+2, host_rvalid and rdata valid at N+3. Next accept earliest N+3.
- Release: RELEASE one cycle; cpu_hold falls the cycle after RELEASE.
- Async reset mid-transaction aborts it; no mem strobe may persist past reset assertion.

## Structure
- Shared `cpu_pkg`: AW/DW defaults, arbiter state encoding (localparams), opcodes already held there.
- One sub-module is natural: `arb_txn_counter` (count, clear, limit compare, fair flag). Everything else stays flat.

## Test plan
- Reset mid-HRD1 -> all strobes 0 and gnt/hold 0 immediately. After release, CPU fetches from address 0 unaffected.
- Host req at idle, boundary high -> hold at N+1 and gnt at N+2. Write 0xA5 to 0x1F -> mem_wr one cycle with addr 0x1F and data 0xA5.
- Host read of 0x03 holding 0x5C -> mem_rd for 2 cycles, host_rvalid=1 with 0x5C exactly 3 cycles after accept.
- HOST_MAX=4, host keeps valid high -> exactly 4 accepts, then RELEASE. Re-request is not granted until boundary toggles 1->0->1.
- Req asserted while CPU mid-instruction (boundary=0 for 5 cycles) -> hold=1, CPU strobes still pass through, gnt only after boundary.
- Req dropped in DRAIN -> back to CPU, hold low next cycle, no host strobes ever issued.
